// File: rtl/riscv_pkg.sv
// Shared RV32I/RV64I decode constants and field layouts.
// Opcode classes, ALU select codes, memop/brop bundles.
package riscv_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SLL  = 4'd3,
        ALU_SLT  = 4'd4,
        ALU_SLTU = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_SRA  = 4'd8,
        ALU_OR   = 4'd9,
        ALU_AND  = 4'd10
    } alusel_e;

    typedef struct packed {
        logic       is_store;
        logic       is_load;
        logic [1:0] size;
    } memop_t;

    typedef struct packed {
        logic       is_ctl;
        logic [2:0] funct3;
    } brop_t;

    function automatic alusel_e alu_f3(
        input logic [2:0] f3,
        input logic       alt
    );
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-source operand resolver: x0, EX bypass, MEM bypass, regfile.
// Ports: src, rf_data, ex_*/mem_* bypass in; data out.
module id_fwd_mux #(
    parameter int XLEN   = 32,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [4:0]      src,
    input  logic [XLEN-1:0] rf_data,
    input  logic            ex_we,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_we,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic [XLEN-1:0] data
);

    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = FWD_EN && ex_we && (ex_rd == src);
    assign mem_hit = FWD_EN && mem_we && (mem_rd == src);

    always_comb begin
        data = rf_data;
        if (src == 5'd0)
            data = '0;
        else if (ex_hit)
            data = ex_data;
        else if (mem_hit)
            data = mem_data;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// Registered RV32I decode stage with forwarding, load-use stall and ID/EX reg.
// Ports: in_* from IF/ID, rs*_ regfile, ex_/mem_ bypass, flush, out_* to EX.
module id_stage_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter bit FWD_EN   = 1'b1,
    parameter int ALUSEL_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [31:0]         in_inst,
    output logic [4:0]          rs1_addr,
    output logic [4:0]          rs2_addr,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    input  logic                ex_we,
    input  logic [4:0]          ex_rd,
    input  logic [XLEN-1:0]     ex_data,
    input  logic                ex_is_load,
    input  logic                mem_we,
    input  logic [4:0]          mem_rd,
    input  logic [XLEN-1:0]     mem_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     out_pc,
    output logic [XLEN-1:0]     out_op1,
    output logic [XLEN-1:0]     out_op2,
    output logic [XLEN-1:0]     out_imm,
    output logic [XLEN-1:0]     out_rs2val,
    output logic [ALUSEL_W-1:0] out_alusel,
    output logic [4:0]          out_rd,
    output logic                out_regwe,
    output logic [3:0]          out_memop,
    output logic [3:0]          out_brop,
    output logic                out_illegal
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rd;

    assign opc      = in_inst[6:0];
    assign f3       = in_inst[14:12];
    assign f7       = in_inst[31:25];
    assign rd       = in_inst[11:7];
    assign rs1_addr = in_inst[19:15];
    assign rs2_addr = in_inst[24:20];

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25],
                    in_inst[11:7]};
    assign imm_b = {{20{in_inst[31]}}, in_inst[7],
                    in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{12{in_inst[31]}}, in_inst[19:12],
                    in_inst[20], in_inst[30:21], 1'b0};

    logic c_op, c_opimm, c_load, c_store, c_branch;
    logic c_jal, c_jalr, c_lui, c_auipc;

    assign c_op     = (opc == OPC_OP);
    assign c_opimm  = (opc == OPC_OPIMM);
    assign c_load   = (opc == OPC_LOAD);
    assign c_store  = (opc == OPC_STORE);
    assign c_branch = (opc == OPC_BRANCH);
    assign c_jal    = (opc == OPC_JAL);
    assign c_jalr   = (opc == OPC_JALR);
    assign c_lui    = (opc == OPC_LUI);
    assign c_auipc  = (opc == OPC_AUIPC);

    // Shift immediates: bit 30 is the SRA flag; bit 25 is shamt[5]
    // only on RV64, otherwise it must be zero.
    logic sh_ok;
    assign sh_ok = ((in_inst[31:26] & 6'b101111) == 6'b0)
                && (XLEN == 64 || !in_inst[25]);

    logic        legal, wr, use1, use2;
    alusel_e     alu;
    logic [31:0] imm32;
    memop_t      mem;
    brop_t       br;

    always_comb begin
        legal = 1'b0;
        wr    = 1'b0;
        use1  = 1'b0;
        use2  = 1'b0;
        alu   = ALU_NOP;
        imm32 = '0;
        mem   = '0;
        br    = '0;
        unique case (1'b1)
            c_op: begin
                legal = (f7 == 7'b0000000)
                     || (f7 == 7'b0100000
                         && (f3 == 3'b000 || f3 == 3'b101));
                alu  = alu_f3(f3, f7[5]);
                wr   = 1'b1;
                use1 = 1'b1;
                use2 = 1'b1;
            end
            c_opimm: begin
                case (f3)
                    3'b001:  legal = sh_ok && !in_inst[30];
                    3'b101:  legal = sh_ok;
                    default: legal = 1'b1;
                endcase
                alu   = alu_f3(f3, f3 == 3'b101 && in_inst[30]);
                imm32 = imm_i;
                wr    = 1'b1;
                use1  = 1'b1;
            end
            c_load: begin
                legal = (f3 != 3'b111)
                     && (XLEN == 64
                         || (f3 != 3'b011 && f3 != 3'b110));
                alu   = ALU_ADD;
                imm32 = imm_i;
                wr    = 1'b1;
                use1  = 1'b1;
                mem   = '{is_store: 1'b0, is_load: 1'b1,
                          size: f3[1:0]};
                br    = '{is_ctl: 1'b0, funct3: f3};
            end
            c_store: begin
                legal = !f3[2] && (XLEN == 64 || f3 != 3'b011);
                alu   = ALU_ADD;
                imm32 = imm_s;
                use1  = 1'b1;
                use2  = 1'b1;
                mem   = '{is_store: 1'b1, is_load: 1'b0,
                          size: f3[1:0]};
                br    = '{is_ctl: 1'b0, funct3: f3};
            end
            c_branch: begin
                legal = (f3[2:1] != 2'b01);
                alu   = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT)
                              : ALU_SUB;
                imm32 = imm_b;
                use1  = 1'b1;
                use2  = 1'b1;
                br    = '{is_ctl: 1'b1, funct3: f3};
            end
            c_jal: begin
                legal = 1'b1;
                alu   = ALU_ADD;
                imm32 = imm_j;
                wr    = 1'b1;
                br    = '{is_ctl: 1'b1, funct3: 3'b000};
            end
            c_jalr: begin
                legal = (f3 == 3'b000);
                alu   = ALU_ADD;
                imm32 = imm_i;
                wr    = 1'b1;
                use1  = 1'b1;
                br    = '{is_ctl: 1'b1, funct3: f3};
            end
            c_lui, c_auipc: begin
                legal = 1'b1;
                alu   = ALU_ADD;
                imm32 = imm_u;
                wr    = 1'b1;
            end
            default: ;
        endcase
        // Illegal ops travel as inert bubbles flagged out_illegal.
        if (!legal) begin
            alu   = ALU_NOP;
            imm32 = '0;
            mem   = '0;
            br    = '0;
            wr    = 1'b0;
            use1  = 1'b0;
            use2  = 1'b0;
        end
    end

    logic [XLEN-1:0] imm, rs1_val, rs2_val, op1, op2;

    assign imm = XLEN'($signed(imm32));

    id_fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd1 (
        .src      (rs1_addr),
        .rf_data  (rs1_data),
        .ex_we    (ex_we),
        .ex_rd    (ex_rd),
        .ex_data  (ex_data),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .data     (rs1_val)
    );

    id_fwd_mux #(.XLEN(XLEN), .FWD_EN(FWD_EN)) u_fwd2 (
        .src      (rs2_addr),
        .rf_data  (rs2_data),
        .ex_we    (ex_we),
        .ex_rd    (ex_rd),
        .ex_data  (ex_data),
        .mem_we   (mem_we),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .data     (rs2_val)
    );

    assign op1 = (c_auipc || c_jal) ? in_pc
               : c_lui ? '0 : rs1_val;
    assign op2 = (c_op || c_branch) ? rs2_val : imm;

    logic hz, adv, take;

    assign hz = in_valid && ex_is_load && ex_we
             && (ex_rd != 5'd0)
             && ((use1 && rs1_addr == ex_rd)
                 || (use2 && rs2_addr == ex_rd));
    assign adv  = !out_valid || out_ready;
    assign take = in_valid && !hz;
    // A flushed wrong-path op is consumed even if it would stall.
    assign in_ready = rst && adv && (flush || !hz);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_op1     <= '0;
            out_op2     <= '0;
            out_imm     <= '0;
            out_rs2val  <= '0;
            out_alusel  <= ALUSEL_W'(ALU_NOP);
            out_rd      <= '0;
            out_regwe   <= 1'b0;
            out_memop   <= '0;
            out_brop    <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            out_valid <= take;
            if (take) begin
                out_pc      <= in_pc;
                out_op1     <= op1;
                out_op2     <= op2;
                out_imm     <= imm;
                out_rs2val  <= rs2_val;
                out_alusel  <= ALUSEL_W'(alu);
                out_rd      <= rd;
                out_regwe   <= legal && wr && (rd != 5'd0);
                out_memop   <= mem;
                out_brop    <= br;
                out_illegal <= !legal;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Random + directed bench for id_stage_pipe against a decode reference model.
// Drives a 32-bit instance throughout and a 64-bit instance at the end.
module tb_id_stage_pipe;

    localparam int A_NOP  = 0, A_ADD = 1, A_SUB = 2, A_SLL = 3;
    localparam int A_SLT  = 4, A_SLTU = 5, A_XOR = 6, A_SRL = 7;
    localparam int A_SRA  = 8, A_OR = 9, A_AND = 10;

    int f3alu [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU,
                      A_XOR, A_SRL, A_OR, A_AND};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] imm;
        logic [31:0] rs2v;
        logic [3:0]  alu;
        logic [4:0]  rd;
        logic        we;
        logic [3:0]  mem;
        logic [3:0]  br;
        logic        ill;
    } exp_t;

    logic        clk, rst;
    logic        in_valid, in_ready, flush, out_ready;
    logic [31:0] in_pc, in_inst;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        ex_we, ex_is_load, mem_we;
    logic [4:0]  ex_rd, mem_rd;
    logic [31:0] ex_data, mem_data;
    logic        out_valid, out_regwe, out_illegal;
    logic [31:0] out_pc, out_op1, out_op2, out_imm, out_rs2val;
    logic [3:0]  out_alusel, out_memop, out_brop;
    logic [4:0]  out_rd;

    logic [31:0] rf [32];

    assign rs1_data = rf[in_inst[19:15]];
    assign rs2_data = rf[in_inst[24:20]];

    id_stage_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_inst(in_inst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_we(ex_we), .ex_rd(ex_rd), .ex_data(ex_data),
        .ex_is_load(ex_is_load),
        .mem_we(mem_we), .mem_rd(mem_rd), .mem_data(mem_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_op1(out_op1), .out_op2(out_op2),
        .out_imm(out_imm), .out_rs2val(out_rs2val),
        .out_alusel(out_alusel), .out_rd(out_rd),
        .out_regwe(out_regwe), .out_memop(out_memop),
        .out_brop(out_brop), .out_illegal(out_illegal)
    );

    logic        d_valid, d_ready, d_oready, d_ovalid;
    logic [63:0] d_pc, d_rs1, d_rs2, d_exd, d_memd;
    logic [31:0] d_inst;
    logic [4:0]  d_a1, d_a2, d_rd;
    logic [63:0] d_op1, d_op2, d_imm, d_rs2v, d_opc;
    logic [3:0]  d_alu, d_mem, d_br;
    logic        d_we, d_ill;

    id_stage_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst),
        .in_valid(d_valid), .in_ready(d_ready),
        .in_pc(d_pc), .in_inst(d_inst),
        .rs1_addr(d_a1), .rs2_addr(d_a2),
        .rs1_data(d_rs1), .rs2_data(d_rs2),
        .ex_we(1'b0), .ex_rd(5'd0), .ex_data(d_exd),
        .ex_is_load(1'b0),
        .mem_we(1'b0), .mem_rd(5'd0), .mem_data(d_memd),
        .flush(1'b0),
        .out_valid(d_ovalid), .out_ready(d_oready),
        .out_pc(d_opc), .out_op1(d_op1), .out_op2(d_op2),
        .out_imm(d_imm), .out_rs2val(d_rs2v),
        .out_alusel(d_alu), .out_rd(d_rd),
        .out_regwe(d_we), .out_memop(d_mem),
        .out_brop(d_br), .out_illegal(d_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    bit   ev;
    exp_t ep;

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [31:0] res(input logic [4:0] s);
        if (s == 5'd0) return 32'd0;
        if (ex_we && ex_rd == s) return ex_data;
        if (mem_we && mem_rd == s) return mem_data;
        return rf[s];
    endfunction

    task automatic ref_dec(input logic [31:0] i,
                           input logic [31:0] pc,
                           output exp_t e,
                           output bit u1, output bit u2);
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] a, b, imm, si;
        logic [3:0]  mem, br;
        int          alu;
        bit          ok, wr;
        f7  = i[31:25];
        f3  = i[14:12];
        a   = res(i[19:15]);
        b   = res(i[24:20]);
        si  = $signed(i) >>> 20;
        ok  = 0; wr = 0; u1 = 0; u2 = 0;
        alu = A_NOP; imm = 0; mem = 0; br = 0;
        case (i[6:0])
            7'h33: begin
                ok  = f7 == 0
                   || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                alu = f3alu[f3] + ((f7 == 7'h20) ? 1 : 0);
                wr = 1; u1 = 1; u2 = 1;
            end
            7'h13: begin
                ok = 1;
                if (f3 == 1) ok = (f7 == 0);
                if (f3 == 5) ok = (f7 == 0 || f7 == 7'h20);
                alu = f3alu[f3] + ((f3 == 5 && i[30]) ? 1 : 0);
                imm = si; wr = 1; u1 = 1;
            end
            7'h03: begin
                ok  = f3 inside {0, 1, 2, 4, 5};
                alu = A_ADD; imm = si; wr = 1; u1 = 1;
                mem = {2'b01, f3[1:0]}; br = {1'b0, f3};
            end
            7'h23: begin
                ok  = f3 <= 2;
                alu = A_ADD;
                imm = {si[31:5], i[11:7]};
                u1 = 1; u2 = 1;
                mem = {2'b10, f3[1:0]}; br = {1'b0, f3};
            end
            7'h63: begin
                ok  = f3 != 2 && f3 != 3;
                alu = f3 < 2 ? A_SUB : (f3 < 6 ? A_SLT : A_SLTU);
                imm = {{20{i[31]}}, i[7], i[30:25],
                       i[11:8], 1'b0};
                u1 = 1; u2 = 1; br = {1'b1, f3};
            end
            7'h6F: begin
                ok = 1; alu = A_ADD; wr = 1; br = 4'b1000;
                imm = {{12{i[31]}}, i[19:12], i[20],
                       i[30:21], 1'b0};
            end
            7'h67: begin
                ok  = f3 == 0; alu = A_ADD; imm = si;
                wr = 1; u1 = 1; br = {1'b1, f3};
            end
            7'h37, 7'h17: begin
                ok = 1; alu = A_ADD; wr = 1;
                imm = {i[31:12], 12'b0};
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            alu = A_NOP; imm = 0; mem = 0; br = 0;
            wr = 0; u1 = 0; u2 = 0;
        end
        e      = '0;
        e.pc   = pc;
        e.op1  = (i[6:0] == 7'h17 || i[6:0] == 7'h6F) ? pc
               : (i[6:0] == 7'h37) ? 32'd0 : a;
        e.op2  = (i[6:0] == 7'h33 || i[6:0] == 7'h63) ? b : imm;
        e.imm  = imm;
        e.rs2v = b;
        e.alu  = 4'(alu);
        e.rd   = i[11:7];
        e.we   = ok && wr && i[11:7] != 0;
        e.mem  = mem;
        e.br   = br;
        e.ill  = !ok;
    endtask

    task automatic check_out();
        chk("valid", out_valid, ev);
        chk("pc", out_pc, ep.pc);
        chk("op1", out_op1, ep.op1);
        chk("op2", out_op2, ep.op2);
        chk("imm", out_imm, ep.imm);
        chk("rs2val", out_rs2val, ep.rs2v);
        chk("alusel", out_alusel, ep.alu);
        chk("rd", out_rd, ep.rd);
        chk("regwe", out_regwe, ep.we);
        chk("memop", out_memop, ep.mem);
        chk("brop", out_brop, ep.br);
        chk("illegal", out_illegal, ep.ill);
    endtask

    task automatic cyc();
        exp_t nx;
        bit   u1, u2, hz, adv;
        #1;
        ref_dec(in_inst, in_pc, nx, u1, u2);
        hz  = in_valid && ex_is_load && ex_we && ex_rd != 0
           && ((u1 && in_inst[19:15] == ex_rd)
               || (u2 && in_inst[24:20] == ex_rd));
        adv = !ev || out_ready;
        chk("in_ready", in_ready, adv && (flush || !hz));
        chk("rs1_addr", rs1_addr, in_inst[19:15]);
        chk("rs2_addr", rs2_addr, in_inst[24:20]);
        if (flush)
            ev = 0;
        else if (adv) begin
            ev = in_valid && !hz;
            if (ev) ep = nx;
        end
        @(posedge clk);
        #1;
        check_out();
    endtask

    function automatic logic [31:0] rnd_inst();
        logic [31:0] r, w;
        logic [4:0]  rd, a, b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        r  = $urandom;
        rd = 5'($urandom_range(0, 7));
        a  = 5'($urandom_range(0, 7));
        b  = 5'($urandom_range(0, 7));
        f3 = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
            0:       f7 = r[31:25];
            1:       f7 = 7'h20;
            default: f7 = 7'h00;
        endcase
        case ($urandom_range(0, 11))
            0, 1:    w = {f7, b, a, f3, rd, 7'h33};
            2, 3:    w = {f7, b, a, f3, rd, 7'h13};
            4:       w = {r[31:20], a, f3, rd, 7'h03};
            5:       w = {r[31:25], b, a, f3, r[11:7], 7'h23};
            6:       w = {r[31:25], b, a, f3, r[11:7], 7'h63};
            7:       w = {r[31:12], rd, 7'h6F};
            8:       w = {r[31:20], a, (r[0] ? f3 : 3'b0),
                          rd, 7'h67};
            9:       w = {r[31:12], rd, 7'h37};
            10:      w = {r[31:12], rd, 7'h17};
            default: w = r;
        endcase
        return w;
    endfunction

    task automatic rnd_inputs();
        in_valid   = $urandom_range(0, 9) < 8;
        out_ready  = $urandom_range(0, 3) != 0;
        flush      = $urandom_range(0, 15) == 0;
        ex_we      = 1'($urandom_range(0, 1));
        ex_rd      = 5'($urandom_range(0, 7));
        ex_data    = $urandom;
        ex_is_load = $urandom_range(0, 3) == 0;
        mem_we     = 1'($urandom_range(0, 1));
        mem_rd     = 5'($urandom_range(0, 7));
        mem_data   = $urandom;
        in_pc      = $urandom & 32'hFFFF_FFFC;
        in_inst    = rnd_inst();
        if ($urandom_range(0, 3) == 0)
            rf[$urandom_range(1, 31)] = $urandom;
    endtask

    task automatic idle_bypass();
        ex_we = 0; ex_rd = 0; ex_data = 0; ex_is_load = 0;
        mem_we = 0; mem_rd = 0; mem_data = 0;
        flush = 0; out_ready = 1; in_valid = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hDEAD_BEEF;
        rf[1] = 32'd5;
        rf[2] = 32'd3;
        rst = 0; in_pc = 32'h100; in_inst = 0;
        idle_bypass();
        in_valid = 0;
        d_valid = 0; d_oready = 1; d_pc = 0; d_inst = 0;
        d_rs1 = 0; d_rs2 = 0; d_exd = 0; d_memd = 0;
        ev = 0; ep = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", in_ready, 0);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        check_out();

        in_valid = 1;
        in_inst  = 32'h402081B3;
        cyc();
        chk("sub_alu", out_alusel, A_SUB);
        chk("sub_op1", out_op1, 5);
        chk("sub_op2", out_op2, 3);
        chk("sub_rd", out_rd, 3);
        chk("sub_we", out_regwe, 1);
        in_inst = 32'h002081B3;
        cyc();
        chk("add_alu", out_alusel, A_ADD);
        chk("add_op1", out_op1, 5);

        ex_we = 1; ex_rd = 1; ex_data = 32'hAA;
        mem_we = 1; mem_rd = 1; mem_data = 32'hBB;
        in_inst = 32'hFFF08213;
        cyc();
        chk("fwd_ex_pri", out_op1, 32'hAA);
        chk("fwd_imm", out_op2, 32'hFFFF_FFFF);
        ex_rd = 0; ex_data = 32'h55; mem_rd = 0;
        in_inst = 32'h00100213;
        cyc();
        chk("fwd_x0", out_op1, 0);

        mem_we = 0;
        ex_we = 1; ex_rd = 1; ex_is_load = 1;
        in_inst = 32'h002081B3;
        #1;
        chk("lu_ready", in_ready, 0);
        cyc();
        chk("lu_bubble", out_valid, 0);
        ex_is_load = 0;
        cyc();
        chk("lu_accept", out_valid, 1);

        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            in_inst = rnd_inst();
            cyc();
            chk("bp_ready", in_ready, 0);
            chk("bp_hold", out_valid, 1);
        end
        flush = 1;
        cyc();
        chk("flush_stall", out_valid, 0);
        flush = 0; out_ready = 1;
        in_inst = 32'h002081B3;
        cyc();
        flush = 1;
        #1;
        chk("flush_ready", in_ready, 1);
        cyc();
        chk("flush_drop", out_valid, 0);

        flush = 0;
        cyc();
        chk("pre_rst_valid", out_valid, 1);
        #2;
        rst = 0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_alusel", out_alusel, A_NOP);
        chk("arst_ready", in_ready, 0);
        ev = 0; ep = '0;
        in_valid = 0;
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        check_out();

        for (int n = 0; n < 3000; n++) begin
            rnd_inputs();
            cyc();
        end

        in_valid = 0;
        d_valid = 1;
        d_inst = 32'h800002B7;
        @(posedge clk);
        #1;
        chk("x64_valid", d_ovalid, 1);
        chk("x64_lui_imm", d_imm, 64'hFFFF_FFFF_8000_0000);
        chk("x64_lui_op2", d_op2, 64'hFFFF_FFFF_8000_0000);
        chk("x64_lui_op1", d_op1, 0);
        chk("x64_lui_we", d_we, 1);
        d_inst = 32'h0000007F;
        @(posedge clk);
        #1;
        chk("x64_ill", d_ill, 1);
        chk("x64_ill_we", d_we, 0);
        d_inst = 32'hFFF08213;
        d_rs1  = 64'h10;
        @(posedge clk);
        #1;
        chk("x64_addi_op1", d_op1, 64'h10);
        chk("x64_addi_op2", d_op2, 64'hFFFF_FFFF_FFFF_FFFF);
        d_inst = 32'h02009093;
        @(posedge clk);
        #1;
        chk("x64_slli32_ill", d_ill, 0);
        chk("x64_slli32_alu", d_alu, A_SLL);
        chk("x64_slli32_op2", d_op2, 64'h20);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
